// File: rtl/in_xif.sv
// CORE-V-XIF memory-channel types shared by the coprocessor and the
// memory responder.
//   x_mem_req_t    : request from the coprocessor (id, addr, mode, we, size,
//                    be, attr, wdata, last, spec)
//   x_mem_resp_t   : same-cycle response to a request (exc, exccode, dbg)
//   x_mem_result_t : delayed load result (id, rdata, err, dbg)
package in_xif;

    localparam int X_ID_WIDTH  = 4;
    localparam int X_MEM_WIDTH = 32;

    typedef struct packed {
        logic [X_ID_WIDTH-1:0]    id;
        logic [31:0]              addr;
        logic [1:0]               mode;
        logic                     we;
        logic [2:0]               size;
        logic [X_MEM_WIDTH/8-1:0] be;
        logic [1:0]               attr;
        logic [X_MEM_WIDTH-1:0]   wdata;
        logic                     last;
        logic                     spec;
    } x_mem_req_t;

    typedef struct packed {
        logic       exc;
        logic [5:0] exccode;
        logic       dbg;
    } x_mem_resp_t;

    typedef struct packed {
        logic [X_ID_WIDTH-1:0]  id;
        logic [X_MEM_WIDTH-1:0] rdata;
        logic                   err;
        logic                   dbg;
    } x_mem_result_t;

endpackage

// File: rtl/pa_rvfpm.sv
// rvfpm constants: RISC-V exception codes reported on the memory response.
package pa_rvfpm;

    localparam logic [5:0] EXC_LD_MISALIGN = 6'd4;
    localparam logic [5:0] EXC_LD_FAULT    = 6'd5;
    localparam logic [5:0] EXC_ST_MISALIGN = 6'd6;
    localparam logic [5:0] EXC_ST_FAULT    = 6'd7;

endpackage

// File: rtl/xif_mem_result_pipe.sv
// Fixed-latency delay line for load results.
//   ck_i, rst_i          : clock, synchronous active-low reset
//   in_valid_i/id/rdata  : load accepted at this edge and the word it read
//   retire_o             : a result will be presented in the next cycle
//   out_valid_o/id/rdata : result, valid exactly LATENCY cycles after accept
// Stage data is zeroed when the stage is empty, so the outputs read 0 between
// results and after reset.
module xif_mem_result_pipe
    import in_xif::*;
#(
    parameter int LATENCY = 2
) (
    input  logic                   ck_i,
    input  logic                   rst_i,
    input  logic                   in_valid_i,
    input  logic [X_ID_WIDTH-1:0]  in_id_i,
    input  logic [X_MEM_WIDTH-1:0] in_rdata_i,
    output logic                   retire_o,
    output logic                   out_valid_o,
    output logic [X_ID_WIDTH-1:0]  out_id_o,
    output logic [X_MEM_WIDTH-1:0] out_rdata_o
);

    logic [LATENCY-1:0]     valid_q;
    logic [X_ID_WIDTH-1:0]  id_q    [LATENCY];
    logic [X_MEM_WIDTH-1:0] rdata_q [LATENCY];

    always_ff @(posedge ck_i) begin
        if (!rst_i) begin
            valid_q <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                id_q[i]    <= '0;
                rdata_q[i] <= '0;
            end
        end else begin
            valid_q[0] <= in_valid_i;
            id_q[0]    <= in_valid_i ? in_id_i : '0;
            rdata_q[0] <= in_valid_i ? in_rdata_i : '0;
            for (int i = 1; i < LATENCY; i++) begin
                valid_q[i] <= valid_q[i-1];
                id_q[i]    <= id_q[i-1];
                rdata_q[i] <= rdata_q[i-1];
            end
        end
    end

    // A load stops occupying a slot on the edge that moves it into the output
    // stage, so the slot is free again in the cycle the result is presented.
    // This lets MAX_OUTSTANDING == LATENCY sustain one load per cycle.
    generate
        if (LATENCY == 1) begin : g_retire_in
            assign retire_o = in_valid_i;
        end else begin : g_retire_stage
            assign retire_o = valid_q[LATENCY-2];
        end
    endgenerate

    assign out_valid_o = valid_q[LATENCY-1];
    assign out_id_o    = id_q[LATENCY-1];
    assign out_rdata_o = rdata_q[LATENCY-1];

endmodule

// File: rtl/xif_mem_responder.sv
// CORE-V-XIF memory responder: word-addressed memory behind the mem_req /
// mem_resp / mem_result channels.
//   ck, rst                    : clock, synchronous active-low reset
//   mem_valid, mem_ready       : request handshake
//   mem_req, mem_resp          : request and its same-cycle response
//   mem_result_valid, mem_result : load result, READ_LATENCY after accept
//   bd_we, bd_addr, bd_wdata   : backdoor word write for preloading
//
// Handshake: a request is accepted at a rising edge where mem_valid and
// mem_ready are both 1; the requester holds mem_req stable while
// mem_valid && !mem_ready. mem_resp is valid only in the accept cycle.
// mem_result has no backpressure and is valid for exactly one cycle.
module xif_mem_responder
    import in_xif::*, pa_rvfpm::*;
#(
    parameter int MEM_WORDS       = 1024,
    parameter int READ_LATENCY    = 2,
    parameter int MAX_OUTSTANDING = 2,
    localparam int AW             = $clog2(MEM_WORDS)
) (
    input  logic          ck,
    input  logic          rst,
    input  logic          mem_valid,
    output logic          mem_ready,
    input  x_mem_req_t    mem_req,
    output x_mem_resp_t   mem_resp,
    output logic          mem_result_valid,
    output x_mem_result_t mem_result,
    input  logic          bd_we,
    input  logic [AW-1:0] bd_addr,
    input  logic [31:0]   bd_wdata
);

    localparam int               CNT_W      = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CNT_W-1:0] MAX_CNT    = CNT_W'(MAX_OUTSTANDING);
    localparam logic [32:0]      BYTE_LIMIT = 33'(4 * MEM_WORDS);

    logic [31:0]      mem_q [MEM_WORDS];
    logic [CNT_W-1:0] outstanding_q, outstanding_d;
    logic             ready_en_q;

    logic             misaligned, out_of_range;
    logic             accept, load_acc, store_acc, retire;
    logic [AW-1:0]    word_idx;
    logic [31:0]      rd_word;
    logic [X_ID_WIDTH-1:0]  res_id;
    logic [X_MEM_WIDTH-1:0] res_rdata;

    // Request checker; misalignment takes priority over the range fault.
    always_comb begin
        unique case (mem_req.size)
            3'd1:    misaligned = mem_req.addr[0];
            3'd2:    misaligned = |mem_req.addr[1:0];
            default: misaligned = 1'b0;
        endcase
        out_of_range = {1'b0, mem_req.addr} >= BYTE_LIMIT;

        mem_resp = '0;
        if (misaligned) begin
            mem_resp.exc     = 1'b1;
            mem_resp.exccode = mem_req.we ? EXC_ST_MISALIGN : EXC_LD_MISALIGN;
        end else if (out_of_range) begin
            mem_resp.exc     = 1'b1;
            mem_resp.exccode = mem_req.we ? EXC_ST_FAULT : EXC_LD_FAULT;
        end
    end

    // Gating with rst keeps a request presented on a reset edge from
    // touching memory or entering the delay line.
    assign accept    = mem_valid && mem_ready && rst;
    assign store_acc = accept && mem_req.we && !mem_resp.exc;
    assign load_acc  = accept && !mem_req.we && !mem_resp.exc;
    assign word_idx  = mem_req.addr[AW+1:2];
    assign rd_word   = mem_q[word_idx];

    // Memory is not reset. The store is written after the backdoor so it
    // wins on a same-word, same-edge collision.
    always_ff @(posedge ck) begin
        if (bd_we) begin
            mem_q[bd_addr] <= bd_wdata;
        end
        if (store_acc) begin
            for (int b = 0; b < 4; b++) begin
                if (mem_req.be[b]) begin
                    mem_q[word_idx][8*b +: 8] <= mem_req.wdata[8*b +: 8];
                end
            end
        end
    end

    always_comb begin
        outstanding_d = outstanding_q;
        if (load_acc && !retire) begin
            outstanding_d = outstanding_q + 1'b1;
        end else if (!load_acc && retire) begin
            outstanding_d = outstanding_q - 1'b1;
        end
    end

    // ready_en_q holds mem_ready low for the cycle after every reset edge.
    always_ff @(posedge ck) begin
        if (!rst) begin
            outstanding_q <= '0;
            ready_en_q    <= 1'b0;
        end else begin
            outstanding_q <= outstanding_d;
            ready_en_q    <= 1'b1;
        end
    end

    assign mem_ready = ready_en_q && (outstanding_q < MAX_CNT);

    xif_mem_result_pipe #(
        .LATENCY (READ_LATENCY)
    ) u_pipe (
        .ck_i        (ck),
        .rst_i       (rst),
        .in_valid_i  (load_acc),
        .in_id_i     (mem_req.id),
        .in_rdata_i  (rd_word),
        .retire_o    (retire),
        .out_valid_o (mem_result_valid),
        .out_id_o    (res_id),
        .out_rdata_o (res_rdata)
    );

    always_comb begin
        mem_result       = '0;
        mem_result.id    = res_id;
        mem_result.rdata = res_rdata;
    end

    // Fields with no effect on this responder.
    logic unused_req;
    assign unused_req = ^{mem_req.mode, mem_req.attr, mem_req.last, mem_req.spec};

endmodule

// File: tb/tb_xif_mem_responder.sv
module tb_xif_mem_responder;
    import in_xif::*;

    localparam int MEM_WORDS = 1024;
    localparam int LAT       = 2;

    logic ck  = 1'b0;
    logic rst = 1'b0;
    always #5 ck = ~ck;

    // Number of rising edges so far.
    int cyc = 0;
    always @(posedge ck) cyc <= cyc + 1;

    // Main instance: defaults (MAX_OUTSTANDING = READ_LATENCY = 2).
    logic          mem_valid = 1'b0;
    x_mem_req_t    mem_req   = '0;
    logic          mem_ready;
    x_mem_resp_t   mem_resp;
    logic          mem_result_valid;
    x_mem_result_t mem_result;

    // Second instance: MAX_OUTSTANDING = 1.
    logic          mem_valid1 = 1'b0;
    x_mem_req_t    mem_req1   = '0;
    logic          mem_ready1;
    x_mem_resp_t   mem_resp1;
    logic          mem_result_valid1;
    x_mem_result_t mem_result1;

    logic          bd_we    = 1'b0;
    logic [9:0]    bd_addr  = '0;
    logic [31:0]   bd_wdata = '0;

    xif_mem_responder u_dut (
        .ck               (ck),
        .rst              (rst),
        .mem_valid        (mem_valid),
        .mem_ready        (mem_ready),
        .mem_req          (mem_req),
        .mem_resp         (mem_resp),
        .mem_result_valid (mem_result_valid),
        .mem_result       (mem_result),
        .bd_we            (bd_we),
        .bd_addr          (bd_addr),
        .bd_wdata         (bd_wdata)
    );

    xif_mem_responder #(.MAX_OUTSTANDING(1)) u_dut1 (
        .ck               (ck),
        .rst              (rst),
        .mem_valid        (mem_valid1),
        .mem_ready        (mem_ready1),
        .mem_req          (mem_req1),
        .mem_resp         (mem_resp1),
        .mem_result_valid (mem_result_valid1),
        .mem_result       (mem_result1),
        .bd_we            (bd_we),
        .bd_addr          (bd_addr),
        .bd_wdata         (bd_wdata)
    );

    // Reference memories and expected-result queues.
    // Entry = {due cycle[31:0], id[3:0], rdata[31:0]}.
    logic [31:0] mem_m  [MEM_WORDS];
    logic [31:0] mem1_m [MEM_WORDS];
    logic [67:0] exp_q[$];
    logic [67:0] exp1_q[$];

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic flag(input string name, input logic [63:0] act);
        checks++;
        failures++;
        $display("FAIL %s: got 0x%0h (cycle %0d)", name, act, cyc);
    endtask

    // {exc, exccode} straight from the address/size rules.
    function automatic logic [6:0] model_resp(input logic we, input logic [2:0] size,
                                              input logic [31:0] addr);
        bit mis;
        mis = (size == 3'd1 && (addr % 2) != 0) || (size == 3'd2 && (addr % 4) != 0);
        if (mis) return {1'b1, (we ? 6'd6 : 6'd4)};
        if (longint'(addr) >= longint'(4 * MEM_WORDS)) return {1'b1, (we ? 6'd7 : 6'd5)};
        return 7'd0;
    endfunction

    // Monitors: compare each presented result with the oldest expectation.
    always @(negedge ck) begin : mon_main
        logic [67:0] e;
        if (mem_result_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                flag("unexpected_result", {28'd0, mem_result.id, mem_result.rdata});
            end else begin
                e = exp_q.pop_front();
                check("result_cycle", 64'(cyc), 64'(e[67:36]));
                check("result_id", 64'(mem_result.id), 64'(e[35:32]));
                check("result_rdata", 64'(mem_result.rdata), 64'(e[31:0]));
                check("result_err_dbg", {mem_result.err, mem_result.dbg}, 64'd0);
            end
        end else if (exp_q.size() != 0) begin
            e = exp_q[0];
            if (int'(e[67:36]) < cyc) begin
                flag("missing_result", {28'd0, e[35:0]});
                void'(exp_q.pop_front());
            end
        end
    end

    always @(negedge ck) begin : mon_max1
        logic [67:0] e;
        if (mem_result_valid1 === 1'b1) begin
            if (exp1_q.size() == 0) begin
                flag("max1_unexpected_result", {28'd0, mem_result1.id, mem_result1.rdata});
            end else begin
                e = exp1_q.pop_front();
                check("max1_result_cycle", 64'(cyc), 64'(e[67:36]));
                check("max1_result_id", 64'(mem_result1.id), 64'(e[35:32]));
                check("max1_result_rdata", 64'(mem_result1.rdata), 64'(e[31:0]));
            end
        end else if (exp1_q.size() != 0) begin
            e = exp1_q[0];
            if (int'(e[67:36]) < cyc) begin
                flag("max1_missing_result", {28'd0, e[35:0]});
                void'(exp1_q.pop_front());
            end
        end
    end

    // Present one request to the main instance (called at a falling edge),
    // check its response, wait for acceptance and update the model.
    task automatic do_req(input logic we, input logic [31:0] addr, input logic [2:0] size,
                          input logic [3:0] be, input logic [31:0] wdata, input logic [3:0] id,
                          input bit hold, output bit was_ready);
        logic [6:0] er;
        int         w;
        int         waits;
        mem_req       = '0;
        mem_req.id    = id;
        mem_req.addr  = addr;
        mem_req.we    = we;
        mem_req.size  = size;
        mem_req.be    = be;
        mem_req.wdata = wdata;
        mem_req.mode  = 2'($urandom);
        mem_req.attr  = 2'($urandom);
        mem_req.last  = 1'($urandom);
        mem_req.spec  = 1'($urandom);
        mem_valid     = 1'b1;
        #1;
        er = model_resp(we, size, addr);
        check("resp_exc", 64'(mem_resp.exc), 64'(er[6]));
        check("resp_exccode", 64'(mem_resp.exccode), 64'(er[5:0]));
        check("resp_dbg", 64'(mem_resp.dbg), 64'd0);
        was_ready = (mem_ready === 1'b1);
        waits = 0;
        while (mem_ready !== 1'b1 && waits < 16) begin
            @(negedge ck);
            #1;
            waits++;
        end
        if (mem_ready !== 1'b1) begin
            flag("ready_timeout", 64'(waits));
        end else if (!er[6]) begin
            w = int'(addr >> 2);
            if (we) begin
                for (int b = 0; b < 4; b++) begin
                    if (be[b]) mem_m[w][8*b +: 8] = wdata[8*b +: 8];
                end
            end else begin
                exp_q.push_back({32'(cyc + LAT), id, mem_m[w]});
            end
        end
        @(negedge ck);
        if (!hold) mem_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q.size() != 0 || exp1_q.size() != 0) && n < 20) begin
            @(negedge ck);
            n++;
        end
        if (exp_q.size() != 0 || exp1_q.size() != 0) begin
            flag("drain_timeout", 64'(exp_q.size() + exp1_q.size()));
            exp_q.delete();
            exp1_q.delete();
        end
    endtask

    // Continuous loads into the MAX_OUTSTANDING=1 instance: ready alternates.
    task automatic max1_test();
        int id1 = 0;
        int w;
        w = $urandom_range(0, MEM_WORDS - 1);
        mem_req1      = '0;
        mem_req1.size = 3'd2;
        mem_req1.addr = 32'(w * 4);
        mem_req1.id   = 4'(id1);
        mem_valid1    = 1'b1;
        for (int i = 0; i < 12; i++) begin
            #1;
            check("max1_ready", 64'(mem_ready1), 64'(i % 2 == 0));
            check("max1_resp_exc", 64'(mem_resp1.exc), 64'd0);
            if (mem_ready1 === 1'b1) begin
                exp1_q.push_back({32'(cyc + LAT), 4'(id1), mem1_m[w]});
                @(negedge ck);
                id1++;
                w = $urandom_range(0, MEM_WORDS - 1);
                mem_req1.addr = 32'(w * 4);
                mem_req1.id   = 4'(id1);
            end else begin
                @(negedge ck);
            end
        end
        mem_valid1 = 1'b0;
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1);
    end

    initial begin : stim
        bit          r;
        logic        we;
        logic [2:0]  size;
        logic [31:0] addr;

        // Preload every word through the backdoor while held in reset.
        for (int i = 0; i < MEM_WORDS; i++) begin
            @(negedge ck);
            bd_we    = 1'b1;
            bd_addr  = 10'(i);
            bd_wdata = (i == 5) ? 32'hDEADBEEF : (i == 8) ? 32'hAAAAAAAA : $urandom;
            mem_m[i]  = bd_wdata;
            mem1_m[i] = bd_wdata;
        end
        @(negedge ck);
        bd_we = 1'b0;
        #1;
        check("reset_ready", 64'(mem_ready), 64'd0);
        check("reset_ready1", 64'(mem_ready1), 64'd0);
        check("reset_result_valid", 64'(mem_result_valid), 64'd0);
        check("reset_result", 64'(mem_result), 64'd0);
        rst = 1'b1;
        @(negedge ck);
        #1;
        check("ready_after_release", 64'(mem_ready), 64'd1);
        @(negedge ck);

        // Backdoor-preloaded word read through a load.
        do_req(1'b0, 32'h14, 3'd2, 4'h0, 32'h0, 4'd3, 1'b0, r);
        drain();

        // Partial store then immediate load of the same word.
        do_req(1'b1, 32'h20, 3'd2, 4'h3, 32'h11223344, 4'd0, 1'b1, r);
        do_req(1'b0, 32'h20, 3'd2, 4'h0, 32'h0, 4'd1, 1'b0, r);
        drain();

        // Misaligned load, out-of-range store, then word 0 must be intact.
        do_req(1'b0, 32'h1002, 3'd2, 4'h0, 32'h0, 4'd4, 1'b1, r);
        do_req(1'b1, 32'h1000, 3'd2, 4'hF, 32'h55555555, 4'd5, 1'b1, r);
        do_req(1'b0, 32'h0, 3'd2, 4'h0, 32'h0, 4'd2, 1'b0, r);
        drain();

        // Eight back-to-back loads, ids 0..7.
        for (int i = 0; i < 8; i++) begin
            do_req(1'b0, 32'($urandom_range(0, MEM_WORDS - 1) * 4), 3'd2, 4'h0, 32'h0,
                   4'(i), (i < 7), r);
            check("b2b_ready", 64'(r), 64'd1);
        end
        drain();

        // Backdoor and store to the same word on the same edge.
        bd_we     = 1'b1;
        bd_addr   = 10'd9;
        bd_wdata  = 32'h0BADF00D;
        mem_m[9]  = bd_wdata;
        mem1_m[9] = bd_wdata;
        do_req(1'b1, 32'h24, 3'd2, 4'hF, 32'hCAFEF00D, 4'd0, 1'b0, r);
        bd_we = 1'b0;
        do_req(1'b0, 32'h24, 3'd2, 4'h0, 32'h0, 4'd6, 1'b0, r);
        drain();

        // Random mix of loads, stores, sizes, alignments and ranges.
        for (int i = 0; i < 80; i++) begin
            we   = 1'($urandom_range(0, 1));
            size = 3'($urandom_range(0, 2));
            if ($urandom_range(0, 7) == 0) addr = 32'($urandom_range(4096, 65535));
            else                           addr = 32'($urandom_range(0, 4095));
            do_req(we, addr, size, 4'($urandom), $urandom, 4'($urandom),
                   ($urandom_range(0, 3) != 0), r);
            if ($urandom_range(0, 3) == 0) begin
                mem_valid = 1'b0;
                repeat ($urandom_range(1, 3)) @(negedge ck);
            end
        end
        mem_valid = 1'b0;
        drain();

        max1_test();
        drain();

        // Reset with loads in flight on both instances.
        do_req(1'b0, 32'h18, 3'd2, 4'h0, 32'h0, 4'hA, 1'b1, r);
        mem_req1      = '0;
        mem_req1.size = 3'd2;
        mem_req1.addr = 32'h40;
        mem_req1.id   = 4'h9;
        mem_valid1    = 1'b1;
        do_req(1'b0, 32'h1C, 3'd2, 4'h0, 32'h0, 4'hB, 1'b0, r);
        mem_valid1 = 1'b0;
        rst        = 1'b0;
        #2;
        exp_q.delete();
        exp1_q.delete();
        repeat (3) begin
            @(negedge ck);
            #1;
            check("rst_ready", 64'(mem_ready), 64'd0);
            check("rst_ready1", 64'(mem_ready1), 64'd0);
            check("rst_result_valid", 64'(mem_result_valid), 64'd0);
            check("rst_result", 64'(mem_result), 64'd0);
        end
        rst = 1'b1;
        #1;
        check("release_ready_same_cycle", 64'(mem_ready), 64'd0);
        @(negedge ck);
        #1;
        check("post_rst_ready", 64'(mem_ready), 64'd1);
        check("post_rst_ready1", 64'(mem_ready1), 64'd1);
        repeat (6) @(negedge ck);

        // Counters restart from zero: alternation and back-to-back resume.
        max1_test();
        for (int i = 0; i < 4; i++) begin
            do_req(1'b0, 32'($urandom_range(0, MEM_WORDS - 1) * 4), 3'd2, 4'h0, 32'h0,
                   4'(i + 8), (i < 3), r);
            check("post_rst_b2b_ready", 64'(r), 64'd1);
        end
        drain();
        repeat (4) @(negedge ck);
        check("final_queue_empty", 64'(exp_q.size() + exp1_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/xif_mem_responder.md
# xif_mem_responder

CORE-V-XIF memory responder: the CPU/memory-side end of the coprocessor memory request/result channels driven by `rvfpm`. Accepts `mem_req` transactions, checks address range and alignment, reads or writes an internal word-addressed memory, answers with `mem_resp` in the handshake cycle, and returns load data on `mem_result` a fixed number of cycles later. Used in the rvfpm testbench and as the reference responder for load/store-capable FP instructions.

## Interface
- `X_ID_WIDTH`, 4: width of transaction id.
- `X_MEM_WIDTH`, 32: data width; only 32 is supported.
- `MEM_WORDS`, 1024: memory depth in 32-bit words; byte address range is 0 .. 4*MEM_WORDS-1.
- `READ_LATENCY`, 2: cycles from accept to `mem_result_valid`; legal range ≥1.
- `MAX_OUTSTANDING`, 2: maximum accepted loads without a delivered result; legal range 1 .. READ_LATENCY.
- `ck` in 1: clock, rising edge.
- `rst` in 1: one clock; reset is synchronous and active-low.
- `mem_valid` in 1: request valid.
- `mem_ready` out 1: responder can accept.
- `mem_req` in `x_mem_req_t`: id, addr, mode, we, size, be, attr, wdata, last, spec.
- `mem_resp` out `x_mem_resp_t`: exc, exccode, dbg; meaningful only in a handshake cycle.
- `mem_result_valid` out 1: load result valid, exactly one cycle, no backpressure.
- `mem_result` out `x_mem_result_t`: id, rdata, err, dbg.
- `bd_we` in 1: backdoor write enable for preload.
- `bd_addr` in $clog2(MEM_WORDS): backdoor word address.
- `bd_wdata` in 32: backdoor write data.

## Operation
- Handshake: accept when `mem_valid && mem_ready` at a rising edge. `mem_req` must be held stable while `mem_valid && !mem_ready`.
- `mem_ready = (outstanding < MAX_OUTSTANDING)`. `outstanding` is a registered counter, so no same-cycle bypass from a retiring result.
- `mem_resp` is combinational from `mem_req`:
  - Misaligned if size=1 and addr[0]≠0, or size=2 and addr[1:0]≠0. This gives exc=1 with exccode 4 for a load and 6 for a store.
  - Otherwise, addr ≥ 4*MEM_WORDS gives exc=1 with exccode 5 for a load and 7 for a store.
  - Otherwise exc=0 and exccode=0. `dbg` is always 0.
- Accepted store with exc=0: write `wdata` to word addr[..:2] under `be` at the accept edge. No `mem_result`, and `outstanding` is unchanged.
- Accepted load with exc=0: read the word at accept time, so it sees all previously accepted stores. The full word is returned regardless of size. The load enters the result delay line and `outstanding` increments.
- Accepted request with exc=1: memory is untouched and no result is produced.
- Result: `mem_result_valid` rises READ_LATENCY cycles after the accept edge, carrying that load's id and rdata, with err=0 and dbg=0. Results are delivered in acceptance order. `outstanding` decrements on the result cycle.
- Same-cycle load accept and result delivery: `outstanding` is unchanged.
- `spec`, `attr`, `mode` and `last` are ignored.
- Backdoor write takes effect at the edge. If it is to the same word as a same-cycle store, the store wins.

## Timing
- Reset (`rst`=0 at an edge) sets:
  - `mem_ready`=0 for that cycle, then 1 after the first edge with `rst`=1.
  - `mem_result_valid`=0, `mem_result`=0, `outstanding`=0.
  - All in-flight results are dropped.
- Memory contents are not reset.
- A load accepted at edge N produces `mem_result_valid`=1 during cycle N+READ_LATENCY, i.e. it is sampled at edge N+READ_LATENCY.
- With MAX_OUTSTANDING=READ_LATENCY, back-to-back loads are accepted every cycle indefinitely.
- With a smaller MAX_OUTSTANDING, `mem_ready` drops once the count reaches the limit and returns the cycle after a result retires.
- A load accepted in the same cycle as a store to the same address, but later in the stream, cannot occur: there is one request per cycle.

## Structure
- `x_mem_req_t`, `x_mem_resp_t` and `x_mem_result_t` come from `in_xif`.
- Exception-code constants (EXC_LD_MISALIGN=4, EXC_LD_FAULT=5, EXC_ST_MISALIGN=6, EXC_ST_FAULT=7) go in `pa_rvfpm`.
- Sub-module `xif_mem_result_pipe` holds the READ_LATENCY-deep valid/id/rdata shift pipeline with synchronous active-low reset.
- The top level holds the memory array, the checker, and the `outstanding` counter.

## Test plan
- Backdoor-write 0xDEADBEEF to word 5, then load addr 0x14 with id 3: `mem_resp.exc`=0, and 2 cycles later `mem_result_valid`=1 with id=3 and rdata=0xDEADBEEF.
- Store 0x11223344 to addr 0x20 with be=0x3 over prior word 0xAAAAAAAA, then immediately load 0x20: rdata=0xAAAA3344, and no result is produced for the store.
- Load addr 0x1002 with size=2: exc=1, exccode=4, no result. Store to addr 0x1000 (≥4*1024): exc=1, exccode=7, memory unchanged.
- 8 back-to-back loads with ids 0..7: `mem_ready` stays 1, and results with ids 0..7 appear on 8 consecutive cycles starting 2 cycles after the first accept.
- With MAX_OUTSTANDING=1 and READ_LATENCY=2, issue continuous loads: `mem_ready` follows the pattern 1,0,1,0…, one accept every 2 cycles, ordering preserved.
- Assert `rst`=0 with 2 loads in flight: no `mem_result_valid` is seen afterward, `mem_ready`=0 during reset and 1 one cycle after release, and `outstanding` restarts at 0.
